sprite_palette_scheduler: RTL and testbench
===========================================

// Module: sprite_palette_scheduler
// PURPOSE
//  Per-pixel scheduler for the shared 3-bit sprite colour palette. Picks the highest-priority
//  opaque sprite layer each pixel, drives the palette select, registers the returned RGB for VGA.
//  Sequences per-layer hit-flash effects (palette override to white, blinking, frame-aligned).
//  Sits between the sprite ROM/layer logic and the VGA colour outputs.
// PARAMETERS
//  NUM_LAYERS    4      sprite layers; layer 0 = highest priority
//  FLASH_FRAMES  24     frames a flash lasts after a hit (>=1)
//  BLINK_FRAMES  4      frames per blink half-period (>=1)
//  FLASH_IDX     3'd2   palette index forced while flash visible (white entry)
//  BG_R/BG_G/BG_B 8'h00 background colour when no layer is opaque
// PORTS
//  Clk          in   1             pixel clock
//  Reset_n      in   1             asynchronous, active-low reset
//  frame_start  in   1             1-cycle pulse, once per frame (vblank start)
//  blank_n      in   1             1 = active video pixel
//  layer_idx    in   3*NUM_LAYERS  layer i index at [3i+2:3i]; 0 = transparent
//  hit          in   NUM_LAYERS    1-cycle pulse per layer: request flash
//  pal_sel      out  3             palette select_input
//  pal_red/pal_green/pal_blue in 8 palette RGB (combinational from pal_sel)
//  Red/Green/Blue out 8            registered pixel colour
//  blank_n_out  out  1             blank_n delayed to align with Red/Green/Blue
//  flash_active out  NUM_LAYERS    1 while layer's flash counter nonzero
// BEHAVIOUR
//  Reset (async, Reset_n=0): all stage regs 0, Red/Green/Blue=0, blank_n_out=0, pal_sel=0,
//   flash counters 0, pending hits 0, flash_active=0. Deassertion mid-frame: resume from zero state.
//  Stage 1 (clk edge n): win = lowest i with layer_idx[i]!=0; s1_idx, s1_layer, s1_opaque,
//   s1_blank <= blank_n. No opaque layer -> s1_opaque=0, s1_idx=0.
//  Palette select (comb. from stage 1): pal_sel = (s1_opaque && vis[s1_layer]) ? FLASH_IDX : s1_idx.
//  Stage 2 (edge n+1): blank_n_out <= s1_blank; RGB <= !s1_blank ? 0 :
//   s1_opaque ? pal_* : BG_*. Latency: layer_idx -> Red/Green/Blue exactly 2 cycles, no stalls.
//  Flash sequencing per layer i:
//   - hit[i] sets pend[i]; pend held until next frame_start (never mid-frame colour change).
//   - frame_start with pend[i] (incl. hit[i] same cycle): cnt=FLASH_FRAMES, blk=0, vis=1, pend=0.
//   - frame_start, no pend, cnt>0: cnt--, blk++; blk==BLINK_FRAMES-1 -> blk=0, vis toggles.
//     cnt reaching 0 -> vis=0.
//   - hit during active flash: re-arms at next frame_start (restart, not extend).
//   - flash_active[i] = (cnt!=0). vis only changes on frame_start cycles.
//  Counter width $clog2(FLASH_FRAMES+1); blk width $clog2(BLINK_FRAMES)+1; no wrap beyond 0.
//  layer_idx / hit on non-frame cycles while blank_n=0 are still accepted (pend only).
// TESTING
//  1. Reset_n=0 mid-stream -> RGB=0, blank_n_out=0, flash_active=0 same cycle (async).
//  2. layer_idx L0=0,L1=4,L2=3, blank_n=1 -> pal_sel=4 after 1 clk; RGB=DA/BE/3D after 2 clks.
//  3. All layers 0, blank_n=1 -> RGB=BG after 2 clks; blank_n=0 -> RGB=0, blank_n_out=0.
//  4. hit[1] mid-frame, L1=5 only -> pal_sel stays 5 until next frame_start, then FLASH_IDX=2
//     (RGB EA/F4/F8) for 4 frames, 5 for 4 frames, alternating; flash_active[1] low after 24 frames.
//  5. hit[0] same cycle as frame_start -> flash starts that frame; hit[0] again at frame 10
//     -> restart at frame 11, flash_active[0] held 24 more frames.
//  6. Flash on L2 but L0 opaque on pixel -> pal_sel = L0 index (no override); L0 transparent -> 2.

Source files
------------

// File: rtl/sprite_palette_scheduler.sv
// Per-pixel sprite layer arbiter driving the shared palette, with per-layer frame-aligned
// hit-flash sequencing (white override, blinking) and a 2-cycle registered RGB output.
module sprite_palette_scheduler #(
    parameter int          NUM_LAYERS   = 4,
    parameter int          FLASH_FRAMES = 24,
    parameter int          BLINK_FRAMES = 4,
    parameter logic [2:0]  FLASH_IDX    = 3'd2,
    parameter logic [7:0]  BG_R         = 8'h00,
    parameter logic [7:0]  BG_G         = 8'h00,
    parameter logic [7:0]  BG_B         = 8'h00
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_start,
    input  logic                    blank_n,
    input  logic [3*NUM_LAYERS-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]   hit,
    output logic [2:0]              pal_sel,
    input  logic [7:0]              pal_red,
    input  logic [7:0]              pal_green,
    input  logic [7:0]              pal_blue,
    output logic [7:0]              Red,
    output logic [7:0]              Green,
    output logic [7:0]              Blue,
    output logic                    blank_n_out,
    output logic [NUM_LAYERS-1:0]   flash_active
);

    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES) + 1;
    localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    logic [2:0]    idx_p1_q,    idx_p1_d;
    logic [LW-1:0] layer_p1_q,  layer_p1_d;
    logic          opaque_p1_q, opaque_p1_d;
    logic          vld_p1_q,    vld_p1_d;
    logic [7:0]    red_p2_q,    red_p2_d;
    logic [7:0]    green_p2_q,  green_p2_d;
    logic [7:0]    blue_p2_q,   blue_p2_d;
    logic          vld_p2_q,    vld_p2_d;

    logic [NUM_LAYERS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_LAYERS-1:0][BLK_W-1:0] blk_q, blk_d;
    logic [NUM_LAYERS-1:0]            vis_q, vis_d;
    logic [NUM_LAYERS-1:0]            pend_q, pend_d;

    // Flash sequencing: all visible state moves only on frame_start.
    always_comb begin
        cnt_d  = cnt_q;
        blk_d  = blk_q;
        vis_d  = vis_q;
        pend_d = pend_q | hit;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (frame_start) begin
                if (pend_q[i] || hit[i]) begin
                    cnt_d[i]  = CNT_W'(FLASH_FRAMES);
                    blk_d[i]  = '0;
                    vis_d[i]  = 1'b1;
                    pend_d[i] = 1'b0;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = sat_dec(cnt_q[i]);
                    if (blk_q[i] == BLK_W'(BLINK_FRAMES - 1)) begin
                        blk_d[i] = '0;
                        vis_d[i] = ~vis_q[i];
                    end else begin
                        blk_d[i] = blk_q[i] + 1'b1;
                    end
                    if (cnt_q[i] == CNT_W'(1))
                        vis_d[i] = 1'b0;
                end
            end
        end
    end

    // Stage 1: priority select of the lowest-numbered opaque layer.
    always_comb begin
        idx_p1_d    = 3'd0;
        layer_p1_d  = '0;
        opaque_p1_d = 1'b0;
        vld_p1_d    = blank_n;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_idx[3*i +: 3] != 3'd0) begin
                idx_p1_d    = layer_idx[3*i +: 3];
                layer_p1_d  = LW'(i);
                opaque_p1_d = 1'b1;
            end
        end
    end

    assign pal_sel = (opaque_p1_q && vis_q[layer_p1_q]) ? FLASH_IDX : idx_p1_q;

    // Stage 2: register the palette answer, or background/black.
    always_comb begin
        vld_p2_d = vld_p1_q;
        if (!vld_p1_q) begin
            red_p2_d   = 8'h00;
            green_p2_d = 8'h00;
            blue_p2_d  = 8'h00;
        end else if (opaque_p1_q) begin
            red_p2_d   = pal_red;
            green_p2_d = pal_green;
            blue_p2_d  = pal_blue;
        end else begin
            red_p2_d   = BG_R;
            green_p2_d = BG_G;
            blue_p2_d  = BG_B;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_p1_q    <= '0;
            layer_p1_q  <= '0;
            opaque_p1_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            red_p2_q    <= '0;
            green_p2_q  <= '0;
            blue_p2_q   <= '0;
            vld_p2_q    <= 1'b0;
            cnt_q       <= '0;
            blk_q       <= '0;
            vis_q       <= '0;
            pend_q      <= '0;
        end else begin
            idx_p1_q    <= idx_p1_d;
            layer_p1_q  <= layer_p1_d;
            opaque_p1_q <= opaque_p1_d;
            vld_p1_q    <= vld_p1_d;
            red_p2_q    <= red_p2_d;
            green_p2_q  <= green_p2_d;
            blue_p2_q   <= blue_p2_d;
            vld_p2_q    <= vld_p2_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            vis_q       <= vis_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        flash_active = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            flash_active[i] = (cnt_q[i] != '0);
    end

    assign Red         = red_p2_q;
    assign Green       = green_p2_q;
    assign Blue        = blue_p2_q;
    assign blank_n_out = vld_p2_q;

endmodule

// File: tb/tb_sprite_palette_scheduler.sv
// Scoreboard bench for sprite_palette_scheduler: frame-structured stimulus, frame-age flash
// model, palette ROM stand-in, 2-cycle RGB queue.
module tb_sprite_palette_scheduler;

    localparam int NL = 4;
    localparam int FF = 24;
    localparam int BF = 4;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          frame_start;
    logic          blank_n;
    logic [11:0]   layer_idx;
    logic [3:0]    hit;
    logic [2:0]    pal_sel;
    logic [7:0]    pal_red, pal_green, pal_blue;
    logic [7:0]    Red, Green, Blue;
    logic          blank_n_out;
    logic [3:0]    flash_active;
    logic [23:0]   pal_word;

    int checks = 0;
    int errors = 0;

    int          age  [NL];
    bit          pend [NL];
    logic [24:0] exp_q[$];
    logic [11:0] pats [6];

    sprite_palette_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .blank_n(blank_n),
        .layer_idx(layer_idx), .hit(hit), .pal_sel(pal_sel),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .Red(Red), .Green(Green), .Blue(Blue),
        .blank_n_out(blank_n_out), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pal_rgb(input logic [2:0] i);
        case (i)
            3'd1:    return 24'hFF0000;
            3'd2:    return 24'hEAF4F8;
            3'd3:    return 24'h203040;
            3'd4:    return 24'hDABE3D;
            3'd5:    return 24'h804020;
            3'd6:    return 24'h10E050;
            3'd7:    return 24'h5A5A5A;
            default: return 24'h000000;
        endcase
    endfunction

    assign pal_word  = pal_rgb(pal_sel);
    assign pal_red   = pal_word[23:16];
    assign pal_green = pal_word[15:8];
    assign pal_blue  = pal_word[7:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            age[i]  = -1;
            pend[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic step(input bit fs, input bit bn, input logic [11:0] li, input logic [3:0] h);
        logic [2:0]  ps;
        logic        op;
        logic [3:0]  act;
        logic [24:0] e;
        frame_start = fs;
        blank_n     = bn;
        layer_idx   = li;
        hit         = h;
        for (int i = 0; i < NL; i++) begin
            if (fs) begin
                if (pend[i] || h[i]) begin
                    age[i]  = 0;
                    pend[i] = 1'b0;
                end else if (age[i] >= 0) begin
                    age[i]++;
                    if (age[i] >= FF) age[i] = -1;
                end
            end else if (h[i]) begin
                pend[i] = 1'b1;
            end
        end
        ps = 3'd0;
        op = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!op && li[3*i +: 3] != 3'd0) begin
                op = 1'b1;
                ps = li[3*i +: 3];
                if (age[i] >= 0 && ((age[i] / BF) % 2 == 0)) ps = 3'd2;
            end
        end
        for (int i = 0; i < NL; i++) act[i] = (age[i] >= 0);
        if (!bn)     e = 25'd0;
        else if (op) e = {1'b1, pal_rgb(ps)};
        else         e = {1'b1, 24'h000000};
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        check_val("pal_sel", 32'(pal_sel), 32'(ps));
        check_val("flash_active", 32'(flash_active), 32'(act));
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_val("rgb", 32'({blank_n_out, Red, Green, Blue}), 32'(e));
        end
    endtask

    task automatic async_reset();
        #1;
        Reset_n = 1'b0;
        #1;
        check_val("rst_rgb", 32'({blank_n_out, Red, Green, Blue}), 32'd0);
        check_val("rst_flash", 32'(flash_active), 32'd0);
        check_val("rst_pal", 32'(pal_sel), 32'd0);
        clear_model();
        #3;
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [11:0] li;
        logic [3:0]  h;
        pats[0] = {3'd0, 3'd3, 3'd4, 3'd0};
        pats[1] = 12'd0;
        pats[2] = {3'd0, 3'd0, 3'd5, 3'd0};
        pats[3] = {3'd0, 3'd6, 3'd0, 3'd1};
        pats[4] = {3'd0, 3'd6, 3'd0, 3'd0};
        pats[5] = {3'd7, 3'd0, 3'd0, 3'd0};
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        blank_n     = 1'b0;
        layer_idx   = '0;
        hit         = '0;
        clear_model();
        repeat (2) @(posedge Clk);
        #1;
        check_val("init_rgb", 32'({blank_n_out, Red, Green, Blue}), 32'd0);
        check_val("init_flash", 32'(flash_active), 32'd0);
        check_val("init_pal", 32'(pal_sel), 32'd0);
        #5;
        Reset_n = 1'b1;

        for (int f = 0; f < 34; f++) begin
            for (int c = 0; c < 8; c++) begin
                li = (c == 7) ? 12'($urandom) : pats[(f * 3 + c) % 6];
                h  = 4'd0;
                if (f == 2  && c == 4) h[1] = 1'b1;
                if (f == 3  && c == 0) h[0] = 1'b1;
                if (f == 5  && c == 1) h[2] = 1'b1;
                if (f == 13 && c == 5) h[0] = 1'b1;
                if (f == 29 && c == 3) h[3] = 1'b1;
                step(c == 0, c >= 2, li, h);
                if (f == 26 && c == 4) async_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
